// File: rtl/ultrasonic_trigger_gen_if.sv
// Signal bundle between the ultrasonic ranging initiator and its surroundings:
// sensor pins, measurement window and per-measurement result strobes.
interface ultrasonic_trigger_gen_if #(
   parameter int CW = 32
);
   logic          enable;
   logic          echo;
   logic          trig;
   logic          dis_start;
   logic          busy;
   logic [CW-1:0] echo_cycles;
   logic          done;
   logic          timeout;

   modport master (
      input  enable, echo,
      output trig, dis_start, busy, echo_cycles, done, timeout
   );

   modport slave (
      output enable, echo,
      input  trig, dis_start, busy, echo_cycles, done, timeout
   );
endinterface

// File: rtl/ultrasonic_trigger_gen.sv
// Periodic ultrasonic trigger generator: fires the sensor trigger, opens the
// measurement window, times the synchronized echo and reports done/timeout.
module ultrasonic_trigger_gen #(
   parameter int TRIG_CYCLES   = 1000,
   parameter int WINDOW_CYCLES = 3000000,
   parameter int PERIOD_CYCLES = 6000000,
   parameter int CW            = 32
) (
   input logic                      clk,
   input logic                      rst,
   ultrasonic_trigger_gen_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_ECHO,
      ECHO_HIGH,
      HOLDOFF
   } state_t;

   localparam logic [CW-1:0] ONE         = CW'(1);
   localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIG_CYCLES - 1);
   localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW_CYCLES - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] period_cnt;
   logic [CW-1:0] window_cnt;
   logic [CW-1:0] width_cnt;
   logic [CW-1:0] width_inc;
   logic          echo_m, echo_s, echo_d;
   logic          echo_rise;
   logic          window_end;

   logic          trig_q, dis_start_q, busy_q, done_q, timeout_q;
   logic [CW-1:0] echo_cycles_q;

   // Raw echo is asynchronous: two flops for metastability, a third for edges.
   // NOTE: non-blocking assignments make each flop take its neighbour's pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= bus.echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign echo_rise  = echo_s & ~echo_d;
   assign window_end = (window_cnt == WINDOW_LAST);
   assign width_inc  = (&width_cnt) ? width_cnt : width_cnt + ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         period_cnt    <= '0;
         window_cnt    <= '0;
         width_cnt     <= '0;
         trig_q        <= 1'b0;
         dis_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         echo_cycles_q <= '0;
      end else begin
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         if (state != IDLE) period_cnt <= period_cnt + ONE;

         case (state)
            IDLE: begin
               if (bus.enable) begin
                  state      <= TRIG;
                  period_cnt <= '0;
                  trig_q     <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end

            TRIG: begin
               if (period_cnt == TRIG_LAST) begin
                  state       <= WAIT_ECHO;
                  window_cnt  <= '0;
                  trig_q      <= 1'b0;
                  dis_start_q <= 1'b1;
               end
            end

            // A rise needs echo_d low, so an echo already high on entry is ignored.
            WAIT_ECHO: begin
               window_cnt <= window_cnt + ONE;
               if (window_end) begin
                  state         <= HOLDOFF;
                  dis_start_q   <= 1'b0;
                  timeout_q     <= 1'b1;
                  echo_cycles_q <= echo_rise ? ONE : '0;
               end else if (echo_rise) begin
                  state     <= ECHO_HIGH;
                  width_cnt <= ONE;
               end
            end

            // Fall is tested first so it wins over a coinciding window expiry.
            ECHO_HIGH: begin
               window_cnt <= window_cnt + ONE;
               if (!echo_s) begin
                  state         <= HOLDOFF;
                  dis_start_q   <= 1'b0;
                  done_q        <= 1'b1;
                  echo_cycles_q <= width_cnt;
               end else begin
                  width_cnt <= width_inc;
                  if (window_end) begin
                     state         <= HOLDOFF;
                     dis_start_q   <= 1'b0;
                     timeout_q     <= 1'b1;
                     echo_cycles_q <= width_inc;
                  end
               end
            end

            HOLDOFF: begin
               if (period_cnt == PERIOD_LAST) begin
                  period_cnt <= '0;
                  if (bus.enable) begin
                     state  <= TRIG;
                     trig_q <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end

            default: begin
               state       <= IDLE;
               trig_q      <= 1'b0;
               dis_start_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.trig        = trig_q;
   assign bus.dis_start   = dis_start_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign bus.echo_cycles = echo_cycles_q;

endmodule
